// File: rtl/image_processing_pkg.sv
// Shared widths, Sobel kernels and the magnitude saturation helper for the
// Bayer-to-edge camera pipeline.
package image_processing_pkg;

   localparam int PIX_W = 12;
   localparam int SUM_W = 14;
   localparam int ACC_W = 16;
   localparam logic [PIX_W-1:0] PIX_MAX = 12'hFFF;

   typedef logic signed [2:0] kernel_t [0:2][0:2];

   // Row 0 is the oldest grey row, column 0 the leftmost (oldest) grey column
   localparam kernel_t KERNEL_GX = '{'{-3'sd1, 3'sd0, 3'sd1},
                                    '{-3'sd2, 3'sd0, 3'sd2},
                                    '{-3'sd1, 3'sd0, 3'sd1}};
   localparam kernel_t KERNEL_GY = '{'{-3'sd1, -3'sd2, -3'sd1},
                                    '{ 3'sd0,  3'sd0,  3'sd0},
                                    '{ 3'sd1,  3'sd2,  3'sd1}};

   function automatic logic [PIX_W-1:0] satAbs(input logic signed [ACC_W-1:0] acc);
      logic [ACC_W-1:0] mag;
      mag = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
      return (mag > ACC_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/image_processing_line_buffer.sv
// Simple dual-port line memory: one write port, one read port with a
// registered read that holds its value until the next read enable.
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 12
) (
   input  logic                     clock,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [WIDTH-1:0]         wrData,
   input  logic                     rdEn,
   input  logic [$clog2(DEPTH)-1:0] rdAddr,
   output logic [WIDTH-1:0]         rdData
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; downstream masking hides stale data
   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
      if (rdEn) begin
         rdData <= mem[rdAddr];
      end
   end

endmodule

// File: rtl/image_processing.sv
// Bayer quad -> grey fold followed by a 3x3 Sobel edge filter; the magnitude
// is driven on all three colour outputs as a half-resolution edge image.
module image_processing
   import image_processing_pkg::*;
#(
   parameter int LINE_WIDTH = 1280,
   parameter int PIX_W      = 12
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [10:0]      iX_Cont,
   input  logic [10:0]      iY_Cont,
   input  logic [PIX_W-1:0] iDATA,
   input  logic             iDVAL,
   input  logic             iSW,
   output logic [PIX_W-1:0] oGrey_R,
   output logic [PIX_W-1:0] oGrey_G,
   output logic [PIX_W-1:0] oGrey_B,
   output logic             oDVAL
);

   localparam int GREY_W  = LINE_WIDTH / 2;
   localparam int RAW_AW  = $clog2(LINE_WIDTH);
   localparam int GREY_AW = $clog2(GREY_W);
   localparam logic [10:0]        LAST_X  = 11'(LINE_WIDTH - 1);
   localparam logic [GREY_AW-1:0] LAST_GX = GREY_AW'(GREY_W - 1);

   logic                   inRange;
   logic                   quadDone;
   logic                   frameStart;
   logic [RAW_AW-1:0]      rawRdAddr;
   logic [GREY_AW-1:0]     quadGx;
   logic [PIX_W-1:0]       rawAbove;
   logic [PIX_W-1:0]       rawAboveLeft;
   logic [PIX_W-1:0]       heldSample;
   logic [SUM_W-1:0]       quadSum;
   logic [PIX_W-1:0]       greyPix;
   logic [GREY_AW-1:0]     gx;
   logic                   greyVld;
   logic [PIX_W-1:0]       line1Rd;
   logic [PIX_W-1:0]       line2Rd;
   logic [PIX_W-1:0]       win     [0:2][0:2];
   logic [PIX_W-1:0]       nextWin [0:2][0:2];
   logic signed [ACC_W-1:0] acc;
   logic [1:0]             rowCnt;

   assign inRange    = iDVAL && (iX_Cont <= LAST_X);
   assign quadDone   = inRange && iY_Cont[0] && iX_Cont[0];
   assign frameStart = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
   assign quadGx     = GREY_AW'(iX_Cont >> 1);

   // The raw buffer is read one column ahead of the write, so the previous row's
   // value survives long enough to be picked up before it is overwritten.
   assign rawRdAddr = (iX_Cont == LAST_X) ? '0 : RAW_AW'(iX_Cont + 11'd1);

   assign quadSum = SUM_W'(rawAboveLeft) + SUM_W'(rawAbove)
                  + SUM_W'(heldSample) + SUM_W'(iDATA);

   line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W)) rawLine (
      .clock  (iCLK),
      .wrEn   (inRange),
      .wrAddr (RAW_AW'(iX_Cont)),
      .wrData (iDATA),
      .rdEn   (inRange),
      .rdAddr (rawRdAddr),
      .rdData (rawAbove)
   );

   line_buffer #(.DEPTH(GREY_W), .WIDTH(PIX_W)) greyLine1 (
      .clock  (iCLK),
      .wrEn   (greyVld),
      .wrAddr (gx),
      .wrData (greyPix),
      .rdEn   (quadDone),
      .rdAddr (quadGx),
      .rdData (line1Rd)
   );

   line_buffer #(.DEPTH(GREY_W), .WIDTH(PIX_W)) greyLine2 (
      .clock  (iCLK),
      .wrEn   (greyVld),
      .wrAddr (gx),
      .wrData (line1Rd),
      .rdEn   (quadDone),
      .rdAddr (quadGx),
      .rdData (line2Rd)
   );

   // Stage 1: track the two above-row samples and the left sample, fold the quad
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rawAboveLeft <= '0;
         heldSample   <= '0;
         greyPix      <= '0;
         gx           <= '0;
         greyVld      <= 1'b0;
      end else begin
         greyVld <= quadDone;
         if (inRange) begin
            rawAboveLeft <= rawAbove;
            heldSample   <= iDATA;
         end
         if (quadDone) begin
            greyPix <= quadSum[SUM_W-1:2];
            gx      <= quadGx;
         end
      end
   end

   // The output is computed from the window as it will look once the new column lands
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 2; c++) begin
            nextWin[r][c] = win[r][c+1];
         end
      end
      nextWin[0][2] = line2Rd;
      nextWin[1][2] = line1Rd;
      nextWin[2][2] = greyPix;
      acc = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            acc = acc + ACC_W'(iSW ? KERNEL_GY[r][c] : KERNEL_GX[r][c])
                      * $signed(ACC_W'(nextWin[r][c]));
         end
      end
   end

   // Stage 2: shift the window, count filled grey rows and register the masked magnitude
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
         rowCnt  <= '0;
         oGrey_R <= '0;
         oDVAL   <= 1'b0;
      end else begin
         oDVAL <= greyVld;
         if (greyVld) begin
            win     <= nextWin;
            oGrey_R <= ((gx < GREY_AW'(2)) || (rowCnt < 2'd2)) ? '0 : satAbs(acc);
         end
         if (frameStart) begin
            rowCnt <= '0;
         end else if (greyVld && (gx == LAST_GX) && (rowCnt != 2'd2)) begin
            rowCnt <= rowCnt + 2'd1;
         end
      end
   end

   assign oGrey_G = oGrey_R;
   assign oGrey_B = oGrey_R;

endmodule

// File: tb/tb_image_processing.sv
// Scoreboard bench for image_processing on a 32-pixel-wide sensor: a frame-level
// reference model queues expected edge values, a negedge monitor checks them.
module tb_image_processing;

   localparam int LW = 32;

   typedef struct {
      logic [11:0] val;
      int          due;
   } expEntry;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [10:0] iX_Cont;
   logic [10:0] iY_Cont;
   logic [11:0] iDATA;
   logic        iDVAL;
   logic        iSW;
   logic [11:0] oGrey_R;
   logic [11:0] oGrey_G;
   logic [11:0] oGrey_B;
   logic        oDVAL;

   int      checks = 0;
   int      errors = 0;
   int      pulses = 0;
   int      cycle  = 0;
   int      rawMem [LW][LW];
   expEntry sb [$];
   expEntry mon;

   image_processing #(.LINE_WIDTH(LW), .PIX_W(12)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iX_Cont (iX_Cont),
      .iY_Cont (iY_Cont),
      .iDATA   (iDATA),
      .iDVAL   (iDVAL),
      .iSW     (iSW),
      .oGrey_R (oGrey_R),
      .oGrey_G (oGrey_G),
      .oGrey_B (oGrey_B),
      .oDVAL   (oDVAL)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int greyAt(int gx, int gy);
      return (rawMem[2*gy][2*gx] + rawMem[2*gy][2*gx+1]
            + rawMem[2*gy+1][2*gx] + rawMem[2*gy+1][2*gx+1]) / 4;
   endfunction

   // Reference Sobel on the full grey image; rows before startGy count as unfilled
   function automatic int expSobel(int gx, int gy, bit sw, int startGy);
      int acc = 0;
      int w;
      if (gx < 2 || (gy - startGy) < 2) return 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w = sw ? (r - 1) * ((c == 1) ? 2 : 1) : (c - 1) * ((r == 1) ? 2 : 1);
            acc += w * greyAt(gx - 2 + c, gy - 2 + r);
         end
      end
      if (acc < 0) acc = -acc;
      return (acc > 4095) ? 4095 : acc;
   endfunction

   // pattern: 0 flat Bayer, 1 vertical edge, 2 ramp, 3 random
   task automatic applyStimulus(input int pattern, input bit sw, input bit bubbles,
                                input bit extra, input int startRow, input int stopAfter);
      int      n = 0;
      int      drives = 0;
      bit      done = 0;
      int      lastX;
      expEntry e;
      for (int y = 0; y < LW; y++) begin
         for (int x = 0; x < LW; x++) begin
            case (pattern)
               0:       rawMem[y][x] = (y % 2 == 0) ? ((x % 2 == 0) ? 200 : 100)
                                                    : ((x % 2 == 0) ? 300 : 200);
               1:       rawMem[y][x] = (x < 16) ? 0 : 4095;
               2:       rawMem[y][x] = 4 * (x / 2);
               default: rawMem[y][x] = int'($urandom_range(0, 4095));
            endcase
         end
      end
      iSW   = sw;
      lastX = extra ? LW + 1 : LW - 1;
      for (int y = startRow; y < LW && !done; y++) begin
         for (int x = 0; x <= lastX && !done; x++) begin
            if (bubbles && (drives % 3 == 2)) begin
               @(posedge iCLK); #1;
               iDVAL = 1'b0;
               iDATA = 12'($urandom);
               drives++;
            end
            @(posedge iCLK); #1;
            iDVAL   = 1'b1;
            iX_Cont = 11'(x);
            iY_Cont = 11'(y);
            if (x < LW) iDATA = 12'(rawMem[y][x]);
            else        iDATA = 12'($urandom);
            drives++;
            if (x < LW) begin
               if ((y % 2 == 1) && (x % 2 == 1)) begin
                  e.val = 12'(expSobel(x / 2, y / 2, sw, startRow / 2));
                  e.due = cycle + 2;
                  sb.push_back(e);
               end
               if (n == stopAfter) done = 1;
               n++;
            end
         end
      end
      @(posedge iCLK); #1;
      iDVAL = 1'b0;
   endtask

   task automatic drain(input int expectCount);
      repeat (6) @(posedge iCLK);
      #1;
      checkOutput("pulseCount", pulses, expectCount);
      checkOutput("scoreboardEmpty", sb.size(), 0);
      sb.delete();
      pulses = 0;
   endtask

   // Every output strobe must match the oldest queued expectation, on time
   always @(negedge iCLK) begin
      if (oDVAL === 1'b1) begin
         pulses++;
         checkOutput("pulseExpected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            mon = sb.pop_front();
            checkOutput("greyR", oGrey_R, mon.val);
            checkOutput("greyG", oGrey_G, mon.val);
            checkOutput("greyB", oGrey_B, mon.val);
            checkOutput("latency", cycle, mon.due);
         end
      end
   end

   initial begin
      iRST    = 1'b1;
      iDVAL   = 1'b0;
      iX_Cont = '0;
      iY_Cont = '0;
      iDATA   = '0;
      iSW     = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      checkOutput("resetDval", oDVAL, 0);
      checkOutput("resetGrey", oGrey_R, 0);
      iRST = 1'b0;

      applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, -1); drain(256);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, -1); drain(256);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, -1); drain(256);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, -1); drain(256);
      applyStimulus(2, 1'b0, 1'b1, 1'b0, 0, -1); drain(256);
      applyStimulus(2, 1'b1, 1'b1, 1'b0, 0, -1); drain(256);
      applyStimulus(3, 1'b0, 1'b1, 1'b1, 0, -1); drain(256);
      applyStimulus(3, 1'b1, 1'b0, 1'b1, 0, -1); drain(256);

      // Stop a ramp frame right after the quad at gx=10, gy=5 and reset under a live output
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 0, 11 * LW + 21);
      @(posedge iCLK); #1;
      checkOutput("liveDval", oDVAL, 1);
      checkOutput("liveGrey", oGrey_R, 32);
      #1 iRST = 1'b1;
      #1;
      checkOutput("asyncRstDval", oDVAL, 0);
      checkOutput("asyncRstGreyR", oGrey_R, 0);
      checkOutput("asyncRstGreyB", oGrey_B, 0);
      sb.delete();
      repeat (3) @(posedge iCLK);
      #1 iRST = 1'b0;
      pulses = 0;

      // Resume mid-frame at raw row 8 without passing through (0,0)
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 8, -1); drain(192);
      applyStimulus(3, 1'b1, 1'b1, 1'b0, 0, -1); drain(256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
